autoseller_front_panel: RTL and testbench

- Customer-side front end for the drink vending seller. Accumulates inserted coins into a credit and turns a button press into a single-cycle purchase request (enable/money/drinktype) to the seller.
- Waits for the seller's registered response (enable/ready/change/drink), reports the vended drink, and pays the change back out one coin per cycle.
- Sits between the coin slot/keypad and the seller core.

---
 rtl/autoseller_pkg.sv | 84 ++++++++
 rtl/change_dispenser.sv | 45 ++++
 rtl/autoseller_front_panel.sv | 179 +++++++++++++++++
 tb/tb_autoseller_front_panel.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/autoseller_pkg.sv
// Shared types, coin/drink codes and prices for the autoseller front panel and seller.
package autoseller_pkg;

  localparam int unsigned MONEY_W = 6;
  localparam int unsigned SUM_W   = MONEY_W + 1;
  localparam int unsigned COIN_W  = 2;
  localparam int unsigned DRINK_W = 2;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [COIN_W-1:0] {
    COIN_1       = 2'd0,
    COIN_5       = 2'd1,
    COIN_10      = 2'd2,
    COIN_INVALID = 2'd3
  } coin_e;

  localparam logic [MONEY_W-1:0] COIN_1_VAL  = 6'd1;
  localparam logic [MONEY_W-1:0] COIN_5_VAL  = 6'd5;
  localparam logic [MONEY_W-1:0] COIN_10_VAL = 6'd10;

  typedef enum logic [DRINK_W-1:0] {
    DRINK_NONE = 2'd0,
    DRINK_1    = 2'd1,
    DRINK_2    = 2'd2,
    DRINK_3    = 2'd3
  } drink_e;

  localparam logic [MONEY_W-1:0] PRICE_NONE = 6'd0;
  localparam logic [MONEY_W-1:0] PRICE_1    = 6'd30;
  localparam logic [MONEY_W-1:0] PRICE_2    = 6'd20;
  localparam logic [MONEY_W-1:0] PRICE_3    = 6'd15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT     = 2'd2,
    ST_DISPENSE = 2'd3
  } panel_state_e;

  // Purchase request payload presented to the seller.
  typedef struct packed {
    logic                enable;
    logic [MONEY_W-1:0]  money;
    logic [DRINK_W-1:0]  drink;
  } seller_req_t;

  // Monetary value of a coin code; the invalid code is worth nothing.
  function automatic logic [MONEY_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    logic [MONEY_W-1:0] val;
    case (code)
      COIN_1:  val = COIN_1_VAL;
      COIN_5:  val = COIN_5_VAL;
      COIN_10: val = COIN_10_VAL;
      default: val = '0;
    endcase
    return val;
  endfunction

  // Largest coin not exceeding the amount still owed.
  function automatic logic [COIN_W-1:0] greedy_coin(input logic [MONEY_W-1:0] amount);
    logic [COIN_W-1:0] code;
    if (amount >= COIN_10_VAL) begin
      code = COIN_10;
    end else if (amount >= COIN_5_VAL) begin
      code = COIN_5;
    end else begin
      code = COIN_1;
    end
    return code;
  endfunction

  // Drink price table shared with the seller model.
  function automatic logic [MONEY_W-1:0] drink_price(input logic [DRINK_W-1:0] drink);
    logic [MONEY_W-1:0] price;
    case (drink)
      DRINK_1: price = PRICE_1;
      DRINK_2: price = PRICE_2;
      DRINK_3: price = PRICE_3;
      default: price = PRICE_NONE;
    endcase
    return price;
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy change emitter: pays a loaded amount out as one coin per cycle, largest first.
module change_dispenser
  import autoseller_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [MONEY_W-1:0] value,
  output logic               chg_valid,
  output logic [COIN_W-1:0]  chg_coin,
  output logic               done
);

  logic [MONEY_W-1:0] rem_q;
  logic [MONEY_W-1:0] src_c;
  logic [COIN_W-1:0]  coin_c;
  logic [MONEY_W-1:0] left_c;

  // First coin comes straight from the loaded value so payout starts on entry.
  always_comb begin
    src_c  = load ? value : rem_q;
    coin_c = greedy_coin(src_c);
    left_c = (src_c == '0) ? '0 : src_c - coin_value(coin_c);
  end

  // Remainder and coin strobe; done marks the cycle of the final coin (or an empty load).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q     <= '0;
      chg_valid <= 1'b0;
      chg_coin  <= '0;
      done      <= 1'b0;
    end else if (load || (rem_q != '0)) begin
      rem_q     <= left_c;
      chg_valid <= (src_c != '0);
      chg_coin  <= (src_c != '0) ? coin_c : '0;
      done      <= (left_c == '0);
    end else begin
      chg_valid <= 1'b0;
      chg_coin  <= '0;
      done      <= 1'b0;
    end
  end

endmodule

// File: rtl/autoseller_front_panel.sv
// Customer-side front panel: coin credit, purchase request, seller response and change payout.
module autoseller_front_panel
  import autoseller_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CREDIT_MAX = 63
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               coin_valid_i,
  input  logic [COIN_W-1:0]  coin_i,
  input  logic               sel_valid_i,
  input  logic [DRINK_W-1:0] sel_type_i,
  output logic               req_enable_o,
  output logic [MONEY_W-1:0] req_money_o,
  output logic [DRINK_W-1:0] req_drink_o,
  input  logic               rsp_ready_i,
  input  logic               rsp_enable_i,
  input  logic [MONEY_W-1:0] rsp_change_i,
  input  logic [DRINK_W-1:0] rsp_drink_i,
  output logic [MONEY_W-1:0] credit_o,
  output logic               busy_o,
  output logic               coin_reject_o,
  output logic               vend_valid_o,
  output logic [DRINK_W-1:0] vend_drink_o,
  output logic               chg_valid_o,
  output logic [COIN_W-1:0]  chg_coin_o,
  output logic               timeout_o
);

  localparam logic [SUM_W-1:0]   CREDIT_CAP = SUM_W'(CREDIT_MAX);
  localparam logic [TIMER_W-1:0] TIMER_END  = TIMER_W'(TIMEOUT);

  panel_state_e        state_q, state_d;
  logic [MONEY_W-1:0]  credit_q, credit_d;
  seller_req_t         req_q, req_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_valid_q, vend_valid_d;
  logic [DRINK_W-1:0]  vend_drink_q, vend_drink_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;

  logic                load_c;
  logic [MONEY_W-1:0]  load_value_c;
  logic                disp_done;
  logic [SUM_W-1:0]    coin_sum_c;
  logic                coin_ok_c;
  logic [TIMER_W-1:0]  timer_inc_c;

  // Seller readiness is advisory; the handshake completes on rsp_enable_i alone.
  logic unused_rsp_ready;
  assign unused_rsp_ready = rsp_ready_i;

  // Coin acceptance: idle, no competing selection, valid code, and no overflow past the ceiling.
  assign coin_sum_c  = {1'b0, credit_q} + {1'b0, coin_value(coin_i)};
  assign coin_ok_c   = (state_q == ST_IDLE) && !sel_valid_i &&
                       (coin_i != COIN_INVALID) && (coin_sum_c <= CREDIT_CAP);
  assign timer_inc_c = timer_q + TIMER_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    req_d         = req_q;
    timer_d       = timer_q;
    coin_reject_d = 1'b0;
    vend_valid_d  = 1'b0;
    vend_drink_d  = '0;
    timeout_d     = 1'b0;
    load_c        = 1'b0;
    load_value_c  = '0;

    if (coin_valid_i) begin
      if (coin_ok_c) begin
        credit_d = coin_sum_c[MONEY_W-1:0];
      end else begin
        coin_reject_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_valid_i && (credit_q != '0)) begin
          if (sel_type_i == DRINK_NONE) begin
            load_c       = 1'b1;
            load_value_c = credit_q;
            credit_d     = '0;
            state_d      = ST_DISPENSE;
          end else begin
            req_d.enable = 1'b1;
            req_d.money  = credit_q;
            req_d.drink  = sel_type_i;
            state_d      = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_d.enable = 1'b0;
        timer_d      = '0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_inc_c;
        if (rsp_enable_i) begin
          load_c       = 1'b1;
          load_value_c = rsp_change_i;
          credit_d     = '0;
          vend_valid_d = (rsp_drink_i != DRINK_NONE);
          vend_drink_d = rsp_drink_i;
          state_d      = ST_DISPENSE;
        end else if (timer_inc_c == TIMER_END) begin
          load_c       = 1'b1;
          load_value_c = credit_q;
          credit_d     = '0;
          timeout_d    = 1'b1;
          state_d      = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        if (disp_done) begin
          req_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      req_q         <= '0;
      timer_q       <= '0;
      coin_reject_q <= 1'b0;
      vend_valid_q  <= 1'b0;
      vend_drink_q  <= '0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      req_q         <= req_d;
      timer_q       <= timer_d;
      coin_reject_q <= coin_reject_d;
      vend_valid_q  <= vend_valid_d;
      vend_drink_q  <= vend_drink_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
    end
  end

  change_dispenser u_change (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load_c),
    .value     (load_value_c),
    .chg_valid (chg_valid_o),
    .chg_coin  (chg_coin_o),
    .done      (disp_done)
  );

  assign req_enable_o  = req_q.enable;
  assign req_money_o   = req_q.money;
  assign req_drink_o   = req_q.drink;
  assign credit_o      = credit_q;
  assign busy_o        = busy_q;
  assign coin_reject_o = coin_reject_q;
  assign vend_valid_o  = vend_valid_q;
  assign vend_drink_o  = vend_drink_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_autoseller_front_panel.sv
// Directed vector bench for the autoseller front panel.
module tb_autoseller_front_panel;
  import autoseller_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       coin_valid_i;
  logic [1:0] coin_i;
  logic       sel_valid_i;
  logic [1:0] sel_type_i;
  logic       req_enable_o;
  logic [5:0] req_money_o;
  logic [1:0] req_drink_o;
  logic       rsp_ready_i;
  logic       rsp_enable_i;
  logic [5:0] rsp_change_i;
  logic [1:0] rsp_drink_i;
  logic [5:0] credit_o;
  logic       busy_o;
  logic       coin_reject_o;
  logic       vend_valid_o;
  logic [1:0] vend_drink_o;
  logic       chg_valid_o;
  logic [1:0] chg_coin_o;
  logic       timeout_o;

  autoseller_front_panel #(.TIMEOUT(8), .CREDIT_MAX(63)) dut (
    .clk(clk), .reset_n(reset_n),
    .coin_valid_i(coin_valid_i), .coin_i(coin_i),
    .sel_valid_i(sel_valid_i), .sel_type_i(sel_type_i),
    .req_enable_o(req_enable_o), .req_money_o(req_money_o), .req_drink_o(req_drink_o),
    .rsp_ready_i(rsp_ready_i), .rsp_enable_i(rsp_enable_i),
    .rsp_change_i(rsp_change_i), .rsp_drink_i(rsp_drink_i),
    .credit_o(credit_o), .busy_o(busy_o), .coin_reject_o(coin_reject_o),
    .vend_valid_o(vend_valid_o), .vend_drink_o(vend_drink_o),
    .chg_valid_o(chg_valid_o), .chg_coin_o(chg_coin_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       cv;
    logic [1:0] coin;
    logic       sv;
    logic [1:0] sel;
    logic       re;
    logic [5:0] chg;
    logic [1:0] rd;
  } in_t;

  typedef struct packed {
    logic [5:0] credit;
    logic       busy;
    logic       rej;
    logic       req;
    logic [5:0] money;
    logic [1:0] rdrink;
    logic       vv;
    logic [1:0] vd;
    logic       cgv;
    logic [1:0] cgc;
    logic       to;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  out_t act;

  assign act = {credit_o, busy_o, coin_reject_o, req_enable_o, req_money_o, req_drink_o,
                vend_valid_o, vend_drink_o, chg_valid_o, chg_coin_o, timeout_o};

  function automatic in_t i_idle();
    return in_t'{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 6'd0, 2'd0};
  endfunction
  function automatic in_t i_coin(input int c);
    return in_t'{1'b1, 2'(c), 1'b0, 2'd0, 1'b0, 6'd0, 2'd0};
  endfunction
  function automatic in_t i_sel(input int t);
    return in_t'{1'b0, 2'd0, 1'b1, 2'(t), 1'b0, 6'd0, 2'd0};
  endfunction
  function automatic in_t i_both(input int c, input int t);
    return in_t'{1'b1, 2'(c), 1'b1, 2'(t), 1'b0, 6'd0, 2'd0};
  endfunction
  function automatic in_t i_rsp(input int chg, input int d);
    return in_t'{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 6'(chg), 2'(d)};
  endfunction

  // Expected outputs: credit, busy, reject, req, money, req drink, vend, vend drink, chg, coin, timeout.
  function automatic out_t o(input int credit, input int busy, input int rej, input int req,
                             input int money, input int rdrink, input int vv, input int vd,
                             input int cgv, input int cgc, input int to);
    return out_t'{6'(credit), 1'(busy), 1'(rej), 1'(req), 6'(money), 2'(rdrink),
                  1'(vv), 2'(vd), 1'(cgv), 2'(cgc), 1'(to)};
  endfunction

  function automatic out_t o_zero();
    return o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic out_t o_credit(input int credit, input int rej);
    return o(credit, 0, rej, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input in_t i, input out_t e);
    vecs.push_back(vec_t'{i, e});
  endtask

  task automatic drive(input in_t i);
    coin_valid_i = i.cv;
    coin_i       = i.coin;
    sel_valid_i  = i.sv;
    sel_type_i   = i.sel;
    rsp_enable_i = i.re;
    rsp_change_i = i.chg;
    rsp_drink_i  = i.rd;
    rsp_ready_i  = 1'b1;
  endtask

  task automatic step(input in_t i);
    drive(i);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input out_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (credit,busy,rej,req,money,rdrink,vv,vd,cgv,cgc,to)",
               name, act, e);
    end
  endtask

  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int chg_cnt;
    bit seen;

    reset_n = 1'b0;
    drive(i_idle());
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", o_zero());
    reset_n = 1'b1;

    // 10,10,10,5 then drink 1; seller returns 5 change and drink 1.
    add(i_coin(2), o_credit(10, 0));
    add(i_coin(2), o_credit(20, 0));
    add(i_coin(2), o_credit(30, 0));
    add(i_coin(1), o_credit(35, 0));
    add(i_sel(1),  o(35, 1, 0, 1, 35, 1, 0, 0, 0, 0, 0));
    add(i_idle(),  o(35, 1, 0, 0, 35, 1, 0, 0, 0, 0, 0));
    add(i_rsp(35 - int'(drink_price(2'd1)), 1), o(0, 1, 0, 0, 35, 1, 1, 1, 1, 1, 0));
    add(i_idle(),  o_zero());

    // Insufficient credit 16: full change 10,5,1, no vend; busy drops coins and selections.
    add(i_coin(2), o_credit(10, 0));
    add(i_coin(1), o_credit(15, 0));
    add(i_coin(0), o_credit(16, 0));
    add(i_sel(1),  o(16, 1, 0, 1, 16, 1, 0, 0, 0, 0, 0));
    add(i_coin(0), o(16, 1, 1, 0, 16, 1, 0, 0, 0, 0, 0));
    add(i_sel(3),  o(16, 1, 0, 0, 16, 1, 0, 0, 0, 0, 0));
    add(i_rsp(16, 0), o(0, 1, 0, 0, 16, 1, 0, 0, 1, 2, 0));
    add(i_rsp(40, 2), o(0, 1, 0, 0, 16, 1, 0, 0, 1, 1, 0));
    add(i_idle(),  o(0, 1, 0, 0, 16, 1, 0, 0, 1, 0, 0));
    add(i_idle(),  o_zero());

    // Selection with zero credit ignored; refund of 7 pays 5,1,1 without a request.
    add(i_sel(2),  o_zero());
    add(i_coin(1), o_credit(5, 0));
    add(i_coin(0), o_credit(6, 0));
    add(i_coin(0), o_credit(7, 0));
    add(i_sel(0),  o(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    add(i_idle(),  o(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(i_idle(),  o(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(i_idle(),  o_zero());

    // Coin and selection together: coin refused, request carries pre-coin credit; zero change.
    add(i_coin(2),    o_credit(10, 0));
    add(i_both(1, 1), o(10, 1, 1, 1, 10, 1, 0, 0, 0, 0, 0));
    add(i_idle(),     o(10, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0));
    add(i_rsp(0, 1),  o(0, 1, 0, 0, 10, 1, 1, 1, 0, 0, 0));
    add(i_idle(),     o_zero());

    // Credit ceiling and invalid coin code.
    for (int k = 0; k < 6; k++) add(i_coin(2), o_credit(10 * (k + 1), 0));
    add(i_coin(1), o_credit(60, 1));
    add(i_coin(0), o_credit(61, 0));
    add(i_coin(3), o_credit(61, 1));
    add(i_coin(0), o_credit(62, 0));
    add(i_coin(0), o_credit(63, 0));
    add(i_coin(0), o_credit(63, 1));

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].in);
      check_out($sformatf("vec%0d", k), vecs[k].exp);
    end

    // Refund 63, then reset during the second change coin.
    step(i_sel(0));
    check_out("refund63_coin1", o(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0));
    step(i_idle());
    check_out("refund63_coin2", o(0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0));
    #2 reset_n = 1'b0;
    #1;
    check_out("async_reset", o_zero());
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", o_zero());
    reset_n = 1'b1;
    chg_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step(i_idle());
      if (chg_valid_o) chg_cnt++;
    end
    chk("no_chg_after_reset", chg_cnt, 0);
    check_out("idle_after_reset", o_zero());

    // Timeout: credit 20, drink 2, seller silent.
    step(i_coin(2));
    check_out("to_coin1", o_credit(10, 0));
    step(i_coin(2));
    check_out("to_coin2", o_credit(20, 0));
    step(i_sel(2));
    check_out("to_req", o(20, 1, 0, 1, 20, 2, 0, 0, 0, 0, 0));
    step(i_idle());
    check_out("to_wait_entry", o(20, 1, 0, 0, 20, 2, 0, 0, 0, 0, 0));
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step(i_idle());
      n = k;
      if (timeout_o) seen = 1'b1;
    end
    chk("timeout_latency", n, 8);
    check_out("timeout_pulse", o(0, 1, 0, 0, 20, 2, 0, 0, 1, 2, 1));
    step(i_rsp(33, 3));
    check_out("late_rsp_dispense", o(0, 1, 0, 0, 20, 2, 0, 0, 1, 2, 0));
    step(i_rsp(33, 3));
    check_out("late_rsp_idle", o_zero());
    step(i_idle());
    check_out("final_idle", o_zero());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
